// File: rtl/fifo_ptr_sync_flags_if.sv
// Pointer-compare bus between a FIFO pointer domain and its flag generator.
interface fifo_ptr_sync_flags_if #(
    parameter int unsigned ADDR_WIDTH = 4
);
    localparam int unsigned PW = ADDR_WIDTH + 1;

    logic [PW-1:0] local_ptr;
    logic [PW-1:0] remote_ptr;
    logic [PW-1:0] sync_ptr;
    logic [PW-1:0] level;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          sync_valid;
    logic          ptr_err;

    // Pointer source side: drives both pointers, observes flags.
    modport master (
        output local_ptr,
        output remote_ptr,
        input  sync_ptr,
        input  level,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
        input  sync_valid,
        input  ptr_err
    );

    // Flag generator side.
    modport slave (
        input  local_ptr,
        input  remote_ptr,
        output sync_ptr,
        output level,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
        output sync_valid,
        output ptr_err
    );
endinterface

// File: rtl/fifo_ptr_sync_flags.sv
// Gray-code pointer synchroniser and FIFO flag generator for one side of an
// asynchronous FIFO (MODE 0 = write side, MODE 1 = read side).
module fifo_ptr_sync_flags #(
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MODE        = 0,
    parameter int unsigned AF_TH       = 2,
    parameter int unsigned AE_TH       = 2
) (
    input logic                  clk,
    input logic                  reset,
    fifo_ptr_sync_flags_if.slave bus
);
    localparam int unsigned PW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 2);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYNC_STAGES + 1);
    localparam logic [PW-1:0]    DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0]    AF_LVL  = PW'(DEPTH - AF_TH);
    localparam logic [PW-1:0]    AE_LVL  = PW'(AE_TH);

    logic [PW-1:0]    remote_gray_c;
    logic [PW-1:0]    sync_q [SYNC_STAGES];
    logic [PW-1:0]    last_prev_q;
    logic [PW-1:0]    decoded_c;
    logic [PW-1:0]    gray_diff_c;
    logic             gray_bad_c;
    logic             gray_bad_q;
    logic [PW-1:0]    level_c;
    logic [CNT_W-1:0] warm_cnt_q;
    logic             valid_c;

    // Binary to gray on the asynchronous pointer before it crosses domains.
    assign remote_gray_c = bus.remote_ptr ^ (bus.remote_ptr >> 1);

    // Gray to binary: each bit is the XOR of itself and all higher bits.
    always_comb begin
        decoded_c = '0;
        for (int i = 0; i < int'(PW); i++) begin
            decoded_c[i] = ^(sync_q[SYNC_STAGES-1] >> i);
        end
    end

    // A legal gray sequence changes at most one bit per cycle.
    assign gray_diff_c = sync_q[SYNC_STAGES-1] ^ last_prev_q;
    assign gray_bad_c  = (gray_diff_c & (gray_diff_c - PW'(1))) != '0;

    // Modulo fill level; the wrap bit separates full from empty.
    always_comb begin
        level_c = '0;
        if (MODE == 0) begin
            level_c = bus.local_ptr - bus.sync_ptr;
        end else begin
            level_c = bus.sync_ptr - bus.local_ptr;
        end
    end

    assign valid_c = (warm_cnt_q == CNT_MAX);

    // Synchroniser chain, last-stage history, and registered decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            last_prev_q  <= '0;
            gray_bad_q   <= 1'b0;
            bus.sync_ptr <= '0;
        end else begin
            sync_q[0] <= remote_gray_c;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            last_prev_q  <= sync_q[SYNC_STAGES-1];
            gray_bad_q   <= gray_bad_c;
            bus.sync_ptr <= decoded_c;
        end
    end

    // Warm-up counter, sticky integrity error and registered flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt_q       <= '0;
            bus.sync_valid   <= 1'b0;
            bus.ptr_err      <= 1'b0;
            bus.level        <= '0;
            bus.full         <= 1'b1;
            bus.empty        <= 1'b1;
            bus.almost_full  <= 1'b1;
            bus.almost_empty <= 1'b1;
        end else begin
            if (!valid_c) begin
                warm_cnt_q <= warm_cnt_q + CNT_W'(1);
            end
            bus.sync_valid <= valid_c;

            // Warm-up transitions out of the reset value are not judged.
            if (bus.sync_valid && ((level_c > DEPTH_P) || gray_bad_q)) begin
                bus.ptr_err <= 1'b1;
            end

            if (valid_c) begin
                bus.level        <= level_c;
                bus.full         <= (level_c == DEPTH_P);
                bus.empty        <= (level_c == '0);
                bus.almost_full  <= (level_c >= AF_LVL);
                bus.almost_empty <= (level_c <= AE_LVL);
            end else begin
                bus.level        <= '0;
                bus.full         <= 1'b1;
                bus.empty        <= 1'b1;
                bus.almost_full  <= 1'b1;
                bus.almost_empty <= 1'b1;
            end
        end
    end
endmodule

// File: doc/fifo_ptr_sync_flags.md
Name: fifo_ptr_sync_flags

Overview:
- Parametrised successor to the single-flag pointer-compare path.
- Takes the binary pointer of the opposite FIFO domain and gray-encodes it. Passes it through a configurable N-stage synchroniser into the local clock domain, then decodes it back to binary.
- Compares the decoded pointer against the local pointer to produce registered full, empty, almost-full and almost-empty flags, plus the fill level and a sticky pointer-integrity error.
- One instance sits on the write side (MODE=0) and one on the read side (MODE=1) of the processor/UART FIFO.

Parameters:
- ADDR_WIDTH, 4: FIFO address bits. DEPTH = 2**ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits, MSB is the wrap bit.
- SYNC_STAGES, 2: synchroniser flop count. Legal range 2..4.
- MODE, 0: 0 = write side (local = wptr, remote = rptr); 1 = read side (local = rptr, remote = wptr).
- AF_TH, 2: almost_full asserts when level >= DEPTH-AF_TH.
- AE_TH, 2: almost_empty asserts when level <= AE_TH.

Ports:
- clk  in  1  local domain clock
- reset  in  1  synchronous, active-high reset
- local_ptr  in  ADDR_WIDTH+1  binary pointer of this domain, already registered in clk
- remote_ptr  in  ADDR_WIDTH+1  binary pointer from the opposite domain, asynchronous to clk
- sync_ptr  out  ADDR_WIDTH+1  remote pointer after synchronisation and gray-to-binary decode
- level  out  ADDR_WIDTH+1  fill level, 0..DEPTH
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= DEPTH-AF_TH
- almost_empty  out  1  level <= AE_TH
- sync_valid  out  1  synchroniser warm-up complete
- ptr_err  out  1  sticky integrity error

Behaviour:
- One clock and one reset: clk, with reset synchronous and active-high. All state updates on posedge clk only.
- Gray encode is combinational on remote_ptr: g = b ^ (b>>1). The gray value then feeds SYNC_STAGES flops in series.
- Decode of the last stage is combinational (prefix XOR from the MSB). The result is registered into sync_ptr.
- Latency:
  - A stable remote_ptr change reaches sync_ptr after SYNC_STAGES+1 cycles.
  - Flags and level follow sync_ptr by one further cycle, so remote-to-flag latency is SYNC_STAGES+2 cycles.
  - Local-to-flag latency is 1 cycle.
- Level arithmetic is modulo 2**(ADDR_WIDTH+1):
  - MODE 0: level = local_ptr - sync_ptr.
  - MODE 1: level = sync_ptr - local_ptr.
  - The wrap bit makes full (addr equal, wrap differs) distinguishable from empty.
- Warm-up counter: counts from 0 after reset deassertion up to SYNC_STAGES+1, then saturates. sync_valid = 1 once saturated.
- While sync_valid = 0, outputs are held conservative: full=1, empty=1, almost_full=1, almost_empty=1, level=0.
- Reset values:
  - All sync flops, sync_ptr, level and the counter = 0.
  - sync_valid = 0, ptr_err = 0.
  - full = empty = almost_full = almost_empty = 1.
- Reset asserted mid-operation returns all state to the reset values on the next edge, regardless of pointer activity.
- ptr_err is set when sync_valid = 1 and either condition holds:
  - (a) the last sync stage differs from its previous-cycle value in more than one bit (gray violation); or
  - (b) the computed level exceeds DEPTH (overrun/underrun).
- ptr_err is sticky and cleared only by reset. Flags keep being computed after ptr_err is set.
- Simultaneous local and remote pointer change in the same cycle: each is applied with its own latency. There is no arbitration.
- Wrap-around (pointer 2**(ADDR_WIDTH+1)-1 to 0) must produce a continuous level with no glitch.

Test Plan (ADDR_WIDTH=4, SYNC_STAGES=2, AF_TH=2, AE_TH=2):
1. Reset held 3 cycles, then released with both pointers at 0 -> sync_valid=0 and all four flags=1 for cycles 1-3; from cycle 4: sync_valid=1, empty=1, full=0, almost_empty=1, level=0.
2. MODE0, remote_ptr=0, local_ptr incremented 0->16 one per cycle -> level follows 1 cycle later; almost_full rises at level 14; full=1 at local_ptr=16 (5'b10000); ptr_err stays 0.
3. MODE0, local_ptr=16 (full), remote_ptr 0->1 -> full drops exactly 4 cycles later; level=15, almost_full=1, sync_ptr=1.
4. MODE0 wrap: local_ptr 31->0 while remote_ptr=17 -> level 14->15 on consecutive cycles, with no intermediate value.
5. MODE1, remote_ptr=5, local_ptr=0 -> empty=0, level=5 after 4 cycles; local_ptr stepped to 5 -> empty=1, almost_empty=1 one cycle later.
6. Error cases:
   - remote_ptr jumps 0->5 (gray 00000->00111) -> ptr_err=1 four cycles later and stays 1 until reset.
   - Separately, MODE0 local_ptr=20 with remote_ptr=0 -> ptr_err=1 (level 20 > 16).
